// File: rtl/pw_entry_buf_pkg.sv
// rtl/pw_entry_buf_pkg.sv - shared types, default sizes and width helpers for the password lock
package pw_lock_pkg;

  typedef enum logic {ST_ENTRY, ST_LOCKOUT} pw_state_t;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_DW     = 4;

  function automatic int count_width(input int digits);
    return $clog2(digits + 1);
  endfunction

  function automatic int tries_width(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

endpackage

// File: rtl/pw_entry_buf_if.sv
// rtl/pw_entry_buf_if.sv - keypad strobes in, entry/result/lock status out
interface pw_entry_buf_if #(
  parameter int DIGITS = pw_lock_pkg::DEF_DIGITS,
  parameter int DW     = pw_lock_pkg::DEF_DW
);
  localparam int CW = pw_lock_pkg::count_width(DIGITS);

  logic                 key_valid;
  logic [DW-1:0]        key_value;
  logic                 key_back;
  logic                 key_clear;
  logic                 key_enter;
  logic                 set_mode;
  logic                 relock;
  logic [DIGITS*DW-1:0] pw_flat;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 match;
  logic                 fail;
  logic                 set_done;
  logic                 unlocked;
  logic                 locked_out;

  modport master (
    output key_valid, key_value, key_back, key_clear, key_enter, set_mode, relock,
    input  pw_flat, count, full, match, fail, set_done, unlocked, locked_out
  );

  modport slave (
    input  key_valid, key_value, key_back, key_clear, key_enter, set_mode, relock,
    output pw_flat, count, full, match, fail, set_done, unlocked, locked_out
  );
endinterface

// File: rtl/pw_entry_buf_lockout_timer.sv
// rtl/pw_entry_buf_lockout_timer.sv - loadable down-counter timing the lockout window
module lockout_timer #(
  parameter int LOCK_CYC = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [$clog2(LOCK_CYC)-1:0] load_value,
  output logic                        done
);
  logic [$clog2(LOCK_CYC)-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_value;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/pw_entry_buf.sv
// rtl/pw_entry_buf.sv - keypad entry buffer with code compare, code programming and try lockout
module pw_entry_buf
  import pw_lock_pkg::*;
#(
  parameter int                   DIGITS     = DEF_DIGITS,
  parameter int                   DW         = DEF_DW,
  parameter int                   MAX_TRIES  = 3,
  parameter int                   LOCK_CYC   = 16,
  parameter logic [DIGITS*DW-1:0] PW_DEFAULT = '0
) (
  input logic           clk,
  input logic           reset,
  pw_entry_buf_if.slave bus
);
  localparam int CW = count_width(DIGITS);
  localparam int RW = tries_width(MAX_TRIES);
  localparam int TW = $clog2(LOCK_CYC);
  localparam int PW = DIGITS * DW;

  pw_state_t     state_q, state_n;
  logic [DW-1:0] slots_q [DIGITS];
  logic [DW-1:0] slots_n [DIGITS];
  logic [CW-1:0] count_q, count_n;
  logic [RW-1:0] tries_q, tries_n;
  logic [PW-1:0] code_q, code_n, entry;
  logic          full_q, unlocked_q, unlocked_n, locked_q;
  logic          match_q, match_n, fail_q, fail_n, set_q, set_n;
  logic          lock_go, timer_done;

  // slot 0 is the first digit typed and lands in the MSBs
  always_comb begin
    entry = '0;
    for (int i = 0; i < DIGITS; i++) entry[(DIGITS-1-i)*DW +: DW] = slots_q[i];
  end

  lockout_timer #(.LOCK_CYC(LOCK_CYC)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (lock_go),
    .load_value (TW'(LOCK_CYC - 1)),
    .done       (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_ENTRY;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_ENTRY:   if (lock_go)    state_n = ST_LOCKOUT;
      ST_LOCKOUT: if (timer_done) state_n = ST_ENTRY;
      default:                    state_n = ST_ENTRY;
    endcase
  end

  always_comb begin
    slots_n    = slots_q;
    count_n    = count_q;
    tries_n    = tries_q;
    code_n     = code_q;
    unlocked_n = unlocked_q;
    match_n    = 1'b0;
    fail_n     = 1'b0;
    set_n      = 1'b0;
    lock_go    = 1'b0;
    if (state_q == ST_ENTRY) begin
      if (bus.key_clear || bus.key_enter) begin
        for (int i = 0; i < DIGITS; i++) slots_n[i] = '0;
        count_n = '0;
      end
      if (bus.key_clear) begin
        // entry already wiped above
      end else if (bus.key_back) begin
        if (count_q != '0) begin
          for (int i = 0; i < DIGITS; i++)
            if (i == int'(count_q) - 1) slots_n[i] = '0;
          count_n = count_q - 1'b1;
        end
      end else if (bus.key_enter) begin
        if (bus.set_mode && unlocked_q) begin
          // short entry while programming is rejected without costing a try
          if (full_q) begin
            code_n = entry;
            set_n  = 1'b1;
          end else begin
            fail_n = 1'b1;
          end
        end else if (full_q && entry == code_q) begin
          match_n    = 1'b1;
          unlocked_n = 1'b1;
          tries_n    = '0;
        end else begin
          fail_n = 1'b1;
          if (int'(tries_q) + 1 == MAX_TRIES) begin
            lock_go    = 1'b1;
            unlocked_n = 1'b0;
            tries_n    = '0;
          end else begin
            tries_n = tries_q + 1'b1;
          end
        end
      end else if (bus.key_valid && !full_q) begin
        for (int i = 0; i < DIGITS; i++)
          if (i == int'(count_q)) slots_n[i] = bus.key_value;
        count_n = count_q + 1'b1;
      end
    end
    if (bus.relock) unlocked_n = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) slots_q[i] <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      tries_q    <= '0;
      code_q     <= PW_DEFAULT;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      set_q      <= 1'b0;
    end else begin
      slots_q    <= slots_n;
      count_q    <= count_n;
      full_q     <= (count_n == CW'(DIGITS));
      tries_q    <= tries_n;
      code_q     <= code_n;
      unlocked_q <= unlocked_n;
      locked_q   <= (state_n == ST_LOCKOUT);
      match_q    <= match_n;
      fail_q     <= fail_n;
      set_q      <= set_n;
    end
  end

  assign bus.pw_flat    = entry;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.match      = match_q;
  assign bus.fail       = fail_q;
  assign bus.set_done   = set_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_q;
endmodule

// File: tb/tb_pw_entry_buf.sv
// tb/tb_pw_entry_buf.sv - scoreboard bench for pw_entry_buf with directed keypad sequences
module tb_pw_entry_buf;
  localparam logic [2:0] EXP_MATCH = 3'b100;
  localparam logic [2:0] EXP_FAIL  = 3'b010;
  localparam logic [2:0] EXP_SET   = 3'b001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [2:0] sb [$];

  always #5 clk = ~clk;

  pw_entry_buf_if #(.DIGITS(4), .DW(4)) b ();

  pw_entry_buf #(
    .DIGITS(4), .DW(4), .MAX_TRIES(3), .LOCK_CYC(16), .PW_DEFAULT(16'h1234)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    b.key_valid = 1'b1;
    b.key_value = v;
    step();
    b.key_valid = 1'b0;
  endtask

  task automatic enter(input logic [2:0] exp);
    sb.push_back(exp);
    b.key_enter = 1'b1;
    step();
    b.key_enter = 1'b0;
  endtask

  task automatic submit(input logic [15:0] c, input logic [2:0] exp);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    enter(exp);
  endtask

  // monitor: every result pulse must match the oldest expectation
  initial begin
    logic [2:0] got;
    logic [2:0] exp;
    forever begin
      @(negedge clk);
      got = {b.match, b.fail, b.set_done};
      if (got != 3'b000) begin
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL pulse_unexpected: got %b expected none at %0t", got, $time);
        end else begin
          exp = sb.pop_front();
          if (got === exp) pass_cnt++;
          else $display("FAIL pulse: got %b expected %b at %0t", got, exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    b.key_valid = 0; b.key_value = 0; b.key_back = 0; b.key_clear = 0;
    b.key_enter = 0; b.set_mode = 0; b.relock = 0;
    step(); step();
    check("rst_count", 32'(b.count), 0);
    check("rst_pw", 32'(b.pw_flat), 0);
    check("rst_full", 32'(b.full), 0);
    check("rst_unlocked", 32'(b.unlocked), 0);
    check("rst_locked", 32'(b.locked_out), 0);
    check("rst_pulses", 32'({b.match, b.fail, b.set_done}), 0);
    reset = 1'b0;
    step();

    // entry and match
    for (int d = 1; d <= 4; d++) press(4'(d));
    check("entry_pw", 32'(b.pw_flat), 32'h1234);
    check("entry_full", 32'(b.full), 1);
    check("entry_count", 32'(b.count), 4);
    enter(EXP_MATCH);
    check("match_unlocked", 32'(b.unlocked), 1);
    check("match_count", 32'(b.count), 0);
    check("match_pw", 32'(b.pw_flat), 0);
    step();

    // overflow and backspace
    for (int d = 5; d <= 9; d++) press(4'(d));
    check("ovf_pw", 32'(b.pw_flat), 32'h5678);
    check("ovf_count", 32'(b.count), 4);
    b.key_back = 1; step(); step(); b.key_back = 0;
    check("back_pw", 32'(b.pw_flat), 32'h5600);
    check("back_count", 32'(b.count), 2);
    check("back_full", 32'(b.full), 0);
    b.key_clear = 1; step(); b.key_clear = 0;
    check("clear_count", 32'(b.count), 0);
    b.key_back = 1; step(); b.key_back = 0;
    check("back0_count", 32'(b.count), 0);
    check("back0_pw", 32'(b.pw_flat), 0);

    // coincident strobes
    press(4'h3);
    b.key_valid = 1; b.key_value = 4'h7; b.key_back = 1; step();
    b.key_valid = 0; b.key_back = 0;
    check("vb_count", 32'(b.count), 0);
    check("vb_pw", 32'(b.pw_flat), 0);
    press(4'h1);
    b.key_clear = 1; b.key_enter = 1; step();
    b.key_clear = 0; b.key_enter = 0;
    check("ce_count", 32'(b.count), 0);
    step(); step();

    // lockout after three failures
    submit(16'h1111, EXP_FAIL);
    submit(16'h1111, EXP_FAIL);
    check("pre_lock", 32'(b.locked_out), 0);
    submit(16'h1111, EXP_FAIL);
    check("lock_set", 32'(b.locked_out), 1);
    check("lock_unlocked", 32'(b.unlocked), 0);
    n = 0;
    while (b.locked_out && n < 40) begin
      n++;
      b.key_valid = 1; b.key_value = 4'h5; b.key_enter = n[0];
      step();
    end
    b.key_valid = 0; b.key_enter = 0;
    check("lock_len", 32'(n), 16);
    check("lock_count", 32'(b.count), 0);
    submit(16'h1234, EXP_MATCH);
    check("post_lock_unlocked", 32'(b.unlocked), 1);

    // program a new code
    b.set_mode = 1;
    submit(16'h9876, EXP_SET);
    b.set_mode = 0;
    b.relock = 1; step(); b.relock = 0;
    check("relock", 32'(b.unlocked), 0);
    submit(16'h1234, EXP_FAIL);
    submit(16'h9876, EXP_MATCH);
    check("new_code_unlocked", 32'(b.unlocked), 1);
    for (int i = 3; i >= 0; i--) press(4'(9 - (3 - i)));
    b.relock = 1;
    enter(EXP_MATCH);
    b.relock = 0;
    check("relock_wins", 32'(b.unlocked), 0);

    // async reset in the middle of a lockout
    submit(16'h1111, EXP_FAIL);
    submit(16'h1111, EXP_FAIL);
    submit(16'h1111, EXP_FAIL);
    step(); step(); step();
    check("mid_lock", 32'(b.locked_out), 1);
    #3 reset = 1'b1;
    #1;
    check("arst_locked", 32'(b.locked_out), 0);
    check("arst_count", 32'(b.count), 0);
    #1 reset = 1'b0;
    step();
    submit(16'h1234, EXP_MATCH);
    check("arst_code", 32'(b.unlocked), 1);

    step(); step();
    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
